// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the memory-encryption arbiter
package ibex_pkg;
  typedef enum logic [1:0] {ENC_IDLE, ENC_ISSUE, ENC_WAIT, ENC_RESP} enc_state_e;
  typedef enum logic {ENC_OWNER_INSTR, ENC_OWNER_DATA} enc_owner_e;
  typedef struct packed {
    logic        locked;
    logic [31:0] value;
  } locked_register_t;
endpackage

// File: rtl/ibex_enc_rr_arb.sv
// ibex_enc_rr_arb: 2-way round-robin grant with last-owner pointer
module ibex_enc_rr_arb import ibex_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       instr_req_i,
  input  logic       data_req_i,
  output logic       instr_gnt_o,
  output logic       data_gnt_o,
  output enc_owner_e owner_o
);
  enc_owner_e last_q, last_d;
  always_comb begin
    owner_o = (instr_req_i && data_req_i) ?
              ((last_q == ENC_OWNER_DATA) ? ENC_OWNER_INSTR : ENC_OWNER_DATA) :
              (data_req_i ? ENC_OWNER_DATA : ENC_OWNER_INSTR);
    instr_gnt_o = en_i && (instr_req_i || data_req_i) && (owner_o == ENC_OWNER_INSTR);
    data_gnt_o  = en_i && (instr_req_i || data_req_i) && (owner_o == ENC_OWNER_DATA);
    last_d      = (instr_gnt_o || data_gnt_o) ? owner_o : last_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= ENC_OWNER_INSTR;
    else last_q <= last_d;
  end
endmodule

// File: rtl/ibex_enc_arbiter.sv
// ibex_enc_arbiter: shares one cipher core between IF and LSU, owns the locked key CSR.
// Optional abort-on-timeout feature enabled by IBEX_ENC_TIMEOUT_EN.
module ibex_enc_arbiter import ibex_pkg::*; #(
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  input  logic [31:0]      instr_data_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             data_req_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_data_i,
  output logic             data_gnt_o,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  output logic             cipher_req_o,
  input  logic             cipher_ready_i,
  output logic [31:0]      cipher_key_o,
  output logic [31:0]      cipher_tweak_o,
  output logic [31:0]      cipher_data_o,
  input  logic             cipher_valid_i,
  input  logic [31:0]      cipher_result_i,
  output logic             cipher_abort_o,
  input  logic             key_wr_i,
  input  logic [31:0]      key_wdata_i,
  input  logic             key_lock_i,
  output locked_register_t key_o,
  output logic             key_wr_err_o
);
  enc_state_e       state_q, state_d;
  enc_owner_e       owner_q, owner;
  locked_register_t key_q;
  logic [31:0]      addr_q, wdata_q, ksnap_q, irdata_q, drdata_q, res;
  logic             wr_err_q, gnt, timeout, done;

  ibex_enc_rr_arb u_arb (
    .clk_i,
    .rst_ni,
    .en_i        (state_q == ENC_IDLE),
    .instr_req_i,
    .data_req_i,
    .instr_gnt_o,
    .data_gnt_o,
    .owner_o     (owner)
  );
  assign gnt = instr_gnt_o | data_gnt_o;

`ifdef IBEX_ENC_TIMEOUT_EN
  logic [9:0] cnt_q;
  logic       err_q;
  assign timeout = (state_q == ENC_ISSUE || state_q == ENC_WAIT) &&
                   (cnt_q == 10'(TimeoutCycles - 1));
  // A result arriving on the timeout cycle completes normally
  assign cipher_abort_o = timeout && !(state_q == ENC_WAIT && cipher_valid_i);
  assign instr_err_o    = instr_rvalid_o & err_q;
  assign data_err_o     = data_rvalid_o & err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (gnt) cnt_q <= '0;
      else if (state_q == ENC_ISSUE || state_q == ENC_WAIT) cnt_q <= cnt_q + 10'd1;
      if (done) err_q <= cipher_abort_o;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^10'(TimeoutCycles);
  assign timeout        = 1'b0;
  assign cipher_abort_o = 1'b0;
  assign instr_err_o    = 1'b0;
  assign data_err_o     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ENC_IDLE:  state_d = gnt ? ENC_ISSUE : ENC_IDLE;
      ENC_ISSUE: state_d = timeout ? ENC_RESP : (cipher_ready_i ? ENC_WAIT : ENC_ISSUE);
      ENC_WAIT:  state_d = (cipher_valid_i || timeout) ? ENC_RESP : ENC_WAIT;
      ENC_RESP:  state_d = ENC_IDLE;
      default:   state_d = ENC_IDLE;
    endcase
    done = (state_d == ENC_RESP) && (state_q != ENC_RESP);
    res  = (state_q == ENC_WAIT && cipher_valid_i) ? cipher_result_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ENC_IDLE;
      owner_q  <= ENC_OWNER_INSTR;
      key_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ksnap_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        owner_q <= owner;
        addr_q  <= (owner == ENC_OWNER_DATA) ? data_addr_i : instr_addr_i;
        wdata_q <= (owner == ENC_OWNER_DATA) ? data_data_i : instr_data_i;
        ksnap_q <= key_q.value;
      end
      if (done && owner_q == ENC_OWNER_INSTR) irdata_q <= res;
      if (done && owner_q == ENC_OWNER_DATA) drdata_q <= res;
      if (key_wr_i && !key_q.locked) key_q.value <= key_wdata_i;
      if (key_lock_i) key_q.locked <= 1'b1;
      wr_err_q <= key_wr_i && key_q.locked;
    end
  end

  assign instr_rvalid_o = (state_q == ENC_RESP) && (owner_q == ENC_OWNER_INSTR);
  assign data_rvalid_o  = (state_q == ENC_RESP) && (owner_q == ENC_OWNER_DATA);
  assign instr_rdata_o  = irdata_q;
  assign data_rdata_o   = drdata_q;
  assign cipher_req_o   = state_q == ENC_ISSUE;
  assign cipher_key_o   = ksnap_q;
  assign cipher_tweak_o = addr_q;
  assign cipher_data_o  = wdata_q;
  assign key_o          = key_q;
  assign key_wr_err_o   = wr_err_q;
endmodule

// File: tb/tb_ibex_enc_arbiter.sv
// tb_ibex_enc_arbiter: directed self-checking bench for ibex_enc_arbiter
module tb_ibex_enc_arbiter;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        instr_req_i = 0, data_req_i = 0;
  logic [31:0] instr_addr_i = 0, instr_data_i = 0, data_addr_i = 0, data_data_i = 0;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o, data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] instr_rdata_o, data_rdata_o;
  logic        cipher_req_o, cipher_abort_o, cipher_ready_i = 0, cipher_valid_i = 0;
  logic [31:0] cipher_key_o, cipher_tweak_o, cipher_data_o, cipher_result_i = 0;
  logic        key_wr_i = 0, key_lock_i = 0, key_wr_err_o;
  logic [31:0] key_wdata_i = 0;
  logic [32:0] key_o;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  ibex_enc_arbiter #(.TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_data_i(instr_data_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_data_i(data_data_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o),
    .cipher_req_o(cipher_req_o), .cipher_ready_i(cipher_ready_i), .cipher_key_o(cipher_key_o),
    .cipher_tweak_o(cipher_tweak_o), .cipher_data_o(cipher_data_o), .cipher_valid_i(cipher_valid_i),
    .cipher_result_i(cipher_result_i), .cipher_abort_o(cipher_abort_o),
    .key_wr_i(key_wr_i), .key_wdata_i(key_wdata_i), .key_lock_i(key_lock_i),
    .key_o(key_o), .key_wr_err_o(key_wr_err_o)
  );

  task automatic test_reset;
    rst_ni = 0;
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if ({instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o,
         cipher_req_o, cipher_abort_o, key_wr_err_o} !== 9'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {instr_gnt_o, data_gnt_o, instr_rvalid_o,
        data_rvalid_o, instr_err_o, data_err_o, cipher_req_o, cipher_abort_o, key_wr_err_o});
    end
    total++;
    if (key_o !== 33'h0) begin bad++; $display("FAIL reset_key got=%h want=0", key_o); end
    total++;
    if ({cipher_key_o, cipher_tweak_o, cipher_data_o, instr_rdata_o, data_rdata_o} !== 160'h0) begin
      bad++; $display("FAIL reset_buses got=%h want=0",
        {cipher_key_o, cipher_tweak_o, cipher_data_o, instr_rdata_o, data_rdata_o});
    end
    rst_ni = 1;
  endtask

  task automatic test_single;
    @(negedge clk);
    data_req_i = 1; data_addr_i = 32'h1000; data_data_i = 32'hA5A5A5A5; cipher_ready_i = 1; #1;
    total++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      bad++; $display("FAIL single_gnt got=%b want=01", {instr_gnt_o, data_gnt_o});
    end
    @(negedge clk); data_req_i = 0; #1;
    total++;
    if ({cipher_req_o, cipher_tweak_o, cipher_data_o} !== {1'b1, 32'h1000, 32'hA5A5A5A5}) begin
      bad++; $display("FAIL single_issue got=%b/%h/%h want=1/00001000/a5a5a5a5",
        cipher_req_o, cipher_tweak_o, cipher_data_o);
    end
    @(negedge clk); cipher_valid_i = 1; cipher_result_i = 32'h12345678; #1;
    total++;
    if (cipher_req_o !== 1'b0) begin bad++; $display("FAIL single_wait_req got=%b want=0", cipher_req_o); end
    @(negedge clk); cipher_valid_i = 0; #1;
    total++;
    if ({data_rvalid_o, data_err_o, instr_rvalid_o, data_rdata_o} !== {3'b100, 32'h12345678}) begin
      bad++; $display("FAIL single_resp got=%b%b%b/%h want=100/12345678",
        data_rvalid_o, data_err_o, instr_rvalid_o, data_rdata_o);
    end
    @(negedge clk); #1;
    total++;
    if ({data_rvalid_o, data_rdata_o} !== {1'b0, 32'h12345678}) begin
      bad++; $display("FAIL single_hold got=%b/%h want=0/12345678", data_rvalid_o, data_rdata_o);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g, exp_v;
    @(negedge clk); rst_ni = 0;
    @(negedge clk); rst_ni = 1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      instr_req_i = 1; data_req_i = 1; cipher_ready_i = 1; cipher_valid_i = 1;
      cipher_result_i = 32'(k); #1;
      exp_g = (k % 4 != 0) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
      exp_v = (k % 4 != 3) ? 2'b00 : (((k / 4) % 2 == 0) ? 2'b01 : 2'b10);
      total++;
      if ({instr_gnt_o, data_gnt_o} !== exp_g) begin
        bad++; $display("FAIL b2b_gnt k=%0d got=%b want=%b", k, {instr_gnt_o, data_gnt_o}, exp_g);
      end
      total++;
      if ({instr_rvalid_o, data_rvalid_o} !== exp_v) begin
        bad++; $display("FAIL b2b_rvalid k=%0d got=%b want=%b", k, {instr_rvalid_o, data_rvalid_o}, exp_v);
      end
      if (exp_v != 2'b00) begin
        total++;
        if ((exp_v[0] ? data_rdata_o : instr_rdata_o) !== 32'(k - 1)) begin
          bad++; $display("FAIL b2b_rdata k=%0d got=%h want=%h", k,
            exp_v[0] ? data_rdata_o : instr_rdata_o, 32'(k - 1));
        end
      end
    end
    @(negedge clk);
    instr_req_i = 0; data_req_i = 0; cipher_ready_i = 0; cipher_valid_i = 0;
  endtask

  task automatic test_key_snapshot;
    @(negedge clk); key_wr_i = 1; key_wdata_i = 32'h11111111;
    @(negedge clk); key_wr_i = 0;
    instr_req_i = 1; instr_addr_i = 32'h2000; instr_data_i = 32'h3; cipher_ready_i = 1; #1;
    total++;
    if (instr_gnt_o !== 1'b1) begin bad++; $display("FAIL snap_gnt got=%b want=1", instr_gnt_o); end
    @(negedge clk); instr_req_i = 0; #1;
    total++;
    if (cipher_key_o !== 32'h11111111) begin
      bad++; $display("FAIL snap_key0 got=%h want=11111111", cipher_key_o);
    end
    @(negedge clk); key_wr_i = 1; key_wdata_i = 32'h22222222; cipher_ready_i = 0;
    @(negedge clk); key_wr_i = 0; #1;
    total++;
    if ({cipher_key_o, key_o[31:0]} !== {32'h11111111, 32'h22222222}) begin
      bad++; $display("FAIL snap_hold got=%h/%h want=11111111/22222222", cipher_key_o, key_o[31:0]);
    end
    cipher_valid_i = 1; cipher_result_i = 32'hCAFE0001;
    @(negedge clk); cipher_valid_i = 0; #1;
    total++;
    if ({instr_rvalid_o, instr_rdata_o} !== {1'b1, 32'hCAFE0001}) begin
      bad++; $display("FAIL snap_resp got=%b/%h want=1/cafe0001", instr_rvalid_o, instr_rdata_o);
    end
    @(negedge clk); instr_req_i = 1;
    @(negedge clk); instr_req_i = 0; cipher_ready_i = 1; #1;
    total++;
    if (cipher_key_o !== 32'h22222222) begin
      bad++; $display("FAIL snap_key1 got=%h want=22222222", cipher_key_o);
    end
    @(negedge clk); cipher_valid_i = 1; cipher_result_i = 32'h0;
    @(negedge clk); cipher_valid_i = 0; cipher_ready_i = 0;
  endtask

  task automatic test_key_lock;
    @(negedge clk); key_wr_i = 1; key_wdata_i = 32'hDEADBEEF;
    @(negedge clk); key_wr_i = 0; key_lock_i = 1; #1;
    total++;
    if (key_wr_err_o !== 1'b0) begin bad++; $display("FAIL lock_err_unlocked got=%b want=0", key_wr_err_o); end
    @(negedge clk); key_lock_i = 0; key_wr_i = 1; key_wdata_i = 32'h0;
    @(negedge clk); key_wr_i = 0; #1;
    total++;
    if (key_wr_err_o !== 1'b1) begin bad++; $display("FAIL lock_err_pulse got=%b want=1", key_wr_err_o); end
    total++;
    if (key_o !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL lock_key got=%h want=1deadbeef", key_o); end
    @(negedge clk);
    data_req_i = 1; data_addr_i = 32'h40; cipher_ready_i = 1; #1;
    total++;
    if ({key_wr_err_o, data_gnt_o} !== 2'b01) begin
      bad++; $display("FAIL lock_err_once_gnt got=%b want=01", {key_wr_err_o, data_gnt_o});
    end
    @(negedge clk); data_req_i = 0; #1;
    total++;
    if (cipher_key_o !== 32'hDEADBEEF) begin bad++; $display("FAIL lock_snap got=%h want=deadbeef", cipher_key_o); end
    @(negedge clk); cipher_valid_i = 1; cipher_result_i = 32'h5;
    @(negedge clk); cipher_valid_i = 0; cipher_ready_i = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); instr_req_i = 1; instr_addr_i = 32'h3000; cipher_ready_i = 1;
    @(negedge clk); instr_req_i = 0;
    @(negedge clk); rst_ni = 0; cipher_ready_i = 0; #1;
    total++;
    if ({cipher_req_o, instr_rvalid_o, data_rvalid_o, cipher_abort_o, key_o, cipher_tweak_o} !== 69'h0) begin
      bad++; $display("FAIL rstmid_state got=%b%b%b%b/%h/%h want=0", cipher_req_o, instr_rvalid_o,
        data_rvalid_o, cipher_abort_o, key_o, cipher_tweak_o);
    end
    @(negedge clk); rst_ni = 1;
    @(negedge clk); cipher_valid_i = 1; cipher_result_i = 32'hBAD;
    @(negedge clk); cipher_valid_i = 0; #1;
    total++;
    if ({instr_rvalid_o, data_rvalid_o, cipher_req_o} !== 3'b000) begin
      bad++; $display("FAIL rstmid_late0 got=%b want=000", {instr_rvalid_o, data_rvalid_o, cipher_req_o});
    end
    @(negedge clk); #1;
    total++;
    if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== 34'h0) begin
      bad++; $display("FAIL rstmid_late1 got=%b%b/%h want=00/0", instr_rvalid_o, data_rvalid_o, instr_rdata_o);
    end
    data_req_i = 1; data_addr_i = 32'h44; data_data_i = 32'h55; cipher_ready_i = 1; #1;
    total++;
    if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin
      bad++; $display("FAIL rstmid_gnt got=%b want=01", {instr_gnt_o, data_gnt_o});
    end
    @(negedge clk); data_req_i = 0; #1;
    total++;
    if ({cipher_tweak_o, cipher_data_o} !== {32'h44, 32'h55}) begin
      bad++; $display("FAIL rstmid_issue got=%h/%h want=00000044/00000055", cipher_tweak_o, cipher_data_o);
    end
    @(negedge clk); cipher_valid_i = 1; cipher_result_i = 32'h0BADF00D;
    @(negedge clk); cipher_valid_i = 0; cipher_ready_i = 0; #1;
    total++;
    if ({data_rvalid_o, data_rdata_o} !== {1'b1, 32'h0BADF00D}) begin
      bad++; $display("FAIL rstmid_resp got=%b/%h want=1/0badf00d", data_rvalid_o, data_rdata_o);
    end
    @(negedge clk); key_wr_i = 1; key_wdata_i = 32'h77; key_lock_i = 1;
    @(negedge clk); key_wr_i = 0; key_lock_i = 0; #1;
    total++;
    if (key_o !== {1'b1, 32'h77}) begin bad++; $display("FAIL wr_and_lock got=%h want=100000077", key_o); end
  endtask

`ifdef IBEX_ENC_TIMEOUT_EN
  task automatic test_timeout;
    @(negedge clk); data_req_i = 1; cipher_ready_i = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); data_req_i = 0; #1;
      total++;
      if (cipher_abort_o !== (k == 8)) begin
        bad++; $display("FAIL to_abort k=%0d got=%b want=%b", k, cipher_abort_o, k == 8);
      end
      total++;
      if (data_rvalid_o !== (k == 9)) begin
        bad++; $display("FAIL to_rvalid k=%0d got=%b want=%b", k, data_rvalid_o, k == 9);
      end
      if (k == 9) begin
        total++;
        if ({data_err_o, data_rdata_o} !== {1'b1, 32'h0}) begin
          bad++; $display("FAIL to_resp got=%b/%h want=1/0", data_err_o, data_rdata_o);
        end
      end
      if (k == 10) begin
        total++;
        if (cipher_req_o !== 1'b0) begin bad++; $display("FAIL to_idle got=%b want=0", cipher_req_o); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_key_snapshot();
    test_key_lock();
    test_reset_mid();
`ifdef IBEX_ENC_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
